ls_queue_unit: RTL and testbench

- Parametrised load/store unit with a DEPTH-entry request queue.
- Accepts load/store requests from the issue stage while earlier ones are still in flight, issues them in order to the data memory port, and returns completion tag, task and load data.
- Adds store-data and load-data paths, a queue-full backpressure signal and an optional memory timeout with error flag.
- Sits between the issue stage and the data-memory bus; feeds the register-file write-back with o_rt_sel/o_ts/o_data.

---
 rtl/ls_queue_unit_if.sv | 54 +++++
 rtl/ls_queue_unit.sv | 179 +++++++++++++++++
 tb/tb_ls_queue_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ls_queue_unit_if.sv
// ls_queue_unit_if: issue-stage request, write-back completion and data-memory
// bus signals of the load/store queue unit.
//   slave  : the load/store unit (consumes requests and memory responses)
//   master : the surrounding issue stage / memory model
interface ls_queue_unit_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RT_W   = 4,
    parameter int unsigned TS_W   = 1,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // issue-stage request side
    logic              bs;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_data;
    logic [TS_W-1:0]   i_ts;
    logic [RT_W-1:0]   i_rt_sel;
    logic              i_ls_sel;
    logic              o_full;
    logic [CNT_W-1:0]  o_count;

    // data-memory bus
    logic              d_mem_rdy;
    logic [DATA_W-1:0] d_mem_rdata;
    logic [ADDR_W-1:0] d_mem_adr;
    logic [DATA_W-1:0] d_mem_wdata;
    logic              d_mem_w;
    logic              d_mem_r;

    // write-back completion side
    logic              o_rdy;
    logic [RT_W-1:0]   o_rt_sel;
    logic [TS_W-1:0]   o_ts;
    logic [DATA_W-1:0] o_data;
    logic              o_err;

    modport slave (
        input  bs, i_address, i_data, i_ts, i_rt_sel, i_ls_sel,
        input  d_mem_rdy, d_mem_rdata,
        output o_full, o_count,
        output d_mem_adr, d_mem_wdata, d_mem_w, d_mem_r,
        output o_rdy, o_rt_sel, o_ts, o_data, o_err
    );

    modport master (
        output bs, i_address, i_data, i_ts, i_rt_sel, i_ls_sel,
        output d_mem_rdy, d_mem_rdata,
        input  o_full, o_count,
        input  d_mem_adr, d_mem_wdata, d_mem_w, d_mem_r,
        input  o_rdy, o_rt_sel, o_ts, o_data, o_err
    );
endinterface

// File: rtl/ls_queue_unit.sv
// ls_queue_unit: load/store unit with a DEPTH-entry in-order request queue.
// Requests are pushed while earlier ones are in flight, issued one at a time
// to the data-memory port, and completed with a one-cycle o_rdy pulse carrying
// the target register, task selector and load data. An optional busy-cycle
// timeout aborts a stuck memory access with o_err.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - ls_queue_unit_if.slave: request in, o_full/o_count, d_mem_* bus,
//          completion o_rdy/o_rt_sel/o_ts/o_data/o_err
module ls_queue_unit #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RT_W    = 4,
    parameter int unsigned TS_W    = 1,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           rst,
    ls_queue_unit_if.slave bus
);
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W   = ADDR_W + DATA_W + TS_W + RT_W + 1;
    localparam int unsigned TMO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TMO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          TMO_EN  = (TIMEOUT > 0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;

    // queue storage, entry layout {address, data, ts, rt_sel, ls_sel}
    logic [ENT_W-1:0]  q_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q;

    // issue registers
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [TS_W-1:0]   ts_q;
    logic [RT_W-1:0]   rt_q;
    logic              ls_q;
    logic              mem_r_q, mem_w_q;
    logic [TMO_W-1:0]  tmo_cnt_q;

    // completion registers
    logic              rdy_q;
    logic [RT_W-1:0]   o_rt_q;
    logic [TS_W-1:0]   o_ts_q;
    logic [DATA_W-1:0] o_data_q;
    logic              o_err_q;

    logic              push_c, pop_c, load_c, tmo_hit_c;
    logic [PTR_W-1:0]  load_ptr_c;
    logic [ENT_W-1:0]  head_c;

    // full is the registered view, so a same-edge pop never makes room
    assign push_c = bus.bs & ~full_q;
    assign head_c = q_mem[load_ptr_c];

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state, issue load / pop decisions
    always_comb begin
        state_d    = state_q;
        load_c     = 1'b0;
        pop_c      = 1'b0;
        tmo_hit_c  = 1'b0;
        load_ptr_c = rd_ptr;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    load_c  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // memory ready wins over a timeout on the same edge
                tmo_hit_c = TMO_EN && !bus.d_mem_rdy && (tmo_cnt_q == TMO_W'(TMO_LIM));
                if (bus.d_mem_rdy || tmo_hit_c) begin
                    pop_c = 1'b1;
                    // an entry pushed on this edge is not yet visible: go idle
                    if (count_q > CNT_W'(1)) begin
                        load_c     = 1'b1;
                        load_ptr_c = rd_ptr + PTR_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // occupancy after this edge
    always_comb begin
        count_d = count_q;
        if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
        else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
    end

    // queue storage write
    always_ff @(posedge clk) begin
        if (!rst && push_c)
            q_mem[wr_ptr] <= {bus.i_address, bus.i_data, bus.i_ts, bus.i_rt_sel, bus.i_ls_sel};
    end

    // pointers, occupancy, issue and completion registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            adr_q     <= '0;
            wdata_q   <= '0;
            ts_q      <= '0;
            rt_q      <= '0;
            ls_q      <= 1'b0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            tmo_cnt_q <= '0;
            rdy_q     <= 1'b0;
            o_rt_q    <= '0;
            o_ts_q    <= '0;
            o_data_q  <= '0;
            o_err_q   <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));

            if (load_c) begin
                {adr_q, wdata_q, ts_q, rt_q, ls_q} <= head_c;
                mem_r_q   <= head_c[0];
                mem_w_q   <= ~head_c[0];
                tmo_cnt_q <= '0;
            end else begin
                if (pop_c) begin
                    mem_r_q <= 1'b0;
                    mem_w_q <= 1'b0;
                end
                if (TMO_EN && state_q == BUSY)
                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end

            rdy_q <= pop_c;
            if (pop_c) begin
                o_rt_q   <= rt_q;
                o_ts_q   <= ts_q;
                o_data_q <= (ls_q && !tmo_hit_c) ? bus.d_mem_rdata : '0;
                o_err_q  <= tmo_hit_c;
            end
        end
    end

    assign bus.o_full      = full_q;
    assign bus.o_count     = count_q;
    assign bus.d_mem_adr   = adr_q;
    assign bus.d_mem_wdata = wdata_q;
    assign bus.d_mem_r     = mem_r_q;
    assign bus.d_mem_w     = mem_w_q;
    assign bus.o_rdy       = rdy_q;
    assign bus.o_rt_sel    = o_rt_q;
    assign bus.o_ts        = o_ts_q;
    assign bus.o_data      = o_data_q;
    assign bus.o_err       = o_err_q;
endmodule

// File: tb/tb_ls_queue_unit.sv
// tb_ls_queue_unit: directed table-driven bench for ls_queue_unit
// (DEPTH=4, TIMEOUT=8). Each vector drives inputs for one clock edge and
// lists the outputs expected just after that edge.
module tb_ls_queue_unit;
    logic clk;
    logic rst;

    ls_queue_unit_if #(.ADDR_W(16), .DATA_W(16), .RT_W(4), .TS_W(1), .DEPTH(4)) bus ();

    ls_queue_unit #(
        .ADDR_W(16), .DATA_W(16), .RT_W(4), .TS_W(1), .DEPTH(4), .TIMEOUT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        bs;
        logic [15:0] addr;
        logic [15:0] data;
        logic        ts;
        logic [3:0]  rt;
        logic        ls;
        logic        rdy;
        logic [15:0] rdata;
        logic        e_full;
        logic [2:0]  e_count;
        logic        e_r;
        logic        e_w;
        logic [15:0] e_adr;
        logic [15:0] e_wdata;
        logic        e_rdy;
        logic [3:0]  e_rt;
        logic        e_ts;
        logic [15:0] e_data;
        logic        e_err;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;
    vec_t tbl[$];

    function automatic vec_t v(
        input string n, input logic r, input logic bs, input logic [15:0] addr,
        input logic [15:0] data, input logic ts, input logic [3:0] rt, input logic ls,
        input logic rdy, input logic [15:0] rdata,
        input logic full, input logic [2:0] cnt, input logic er, input logic ew,
        input logic [15:0] adr, input logic [15:0] wdata, input logic ordy,
        input logic [3:0] ort, input logic ots, input logic [15:0] odata, input logic oerr);
        vec_t x;
        x.name = n; x.rst = r; x.bs = bs; x.addr = addr; x.data = data; x.ts = ts;
        x.rt = rt; x.ls = ls; x.rdy = rdy; x.rdata = rdata;
        x.e_full = full; x.e_count = cnt; x.e_r = er; x.e_w = ew; x.e_adr = adr;
        x.e_wdata = wdata; x.e_rdy = ordy; x.e_rt = ort; x.e_ts = ots;
        x.e_data = odata; x.e_err = oerr;
        return x;
    endfunction

    // drive one vector, clock it, compare just after the edge
    task automatic apply(input vec_t x);
        logic [60:0] act, exp;
        logic [15:0] a_adr, a_wd, e_adr, e_wd;
        rst             = x.rst;
        bus.bs          = x.bs;
        bus.i_address   = x.addr;
        bus.i_data      = x.data;
        bus.i_ts        = x.ts;
        bus.i_rt_sel    = x.rt;
        bus.i_ls_sel    = x.ls;
        bus.d_mem_rdy   = x.rdy;
        bus.d_mem_rdata = x.rdata;
        @(posedge clk);
        #1;
        // address/data only matter while a strobe is expected (or in reset)
        if (x.e_r || x.e_w || x.rst) begin
            a_adr = bus.d_mem_adr; a_wd = bus.d_mem_wdata;
            e_adr = x.e_adr;       e_wd = x.e_wdata;
        end else begin
            a_adr = '0; a_wd = '0; e_adr = '0; e_wd = '0;
        end
        act = {bus.o_full, bus.o_count, bus.d_mem_r, bus.d_mem_w, a_adr, a_wd,
               bus.o_rdy, bus.o_rt_sel, bus.o_ts, bus.o_data, bus.o_err};
        exp = {x.e_full, x.e_count, x.e_r, x.e_w, e_adr, e_wd,
               x.e_rdy, x.e_rt, x.e_ts, x.e_data, x.e_err};
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got full=%b cnt=%0d r=%b w=%b adr=%h wd=%h rdy=%b rt=%h ts=%b data=%h err=%b, want full=%b cnt=%0d r=%b w=%b adr=%h wd=%h rdy=%b rt=%h ts=%b data=%h err=%b",
                     x.name, bus.o_full, bus.o_count, bus.d_mem_r, bus.d_mem_w, a_adr, a_wd,
                     bus.o_rdy, bus.o_rt_sel, bus.o_ts, bus.o_data, bus.o_err,
                     x.e_full, x.e_count, x.e_r, x.e_w, e_adr, e_wd,
                     x.e_rdy, x.e_rt, x.e_ts, x.e_data, x.e_err);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            name       rst bs addr     data     ts rt  ls rdy rdata     full cnt r  w  adr      wdata    ordy rt  ts odata    err
        tbl.push_back(v("reset",   1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0));
        // single load
        tbl.push_back(v("ld_push", 0, 1, 16'h1234, 16'h0000, 0, 5, 1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0));
        tbl.push_back(v("ld_iss",  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 16'h1234, 16'h0000, 0, 0, 0, 16'h0000, 0));
        tbl.push_back(v("ld_wait", 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 16'h1234, 16'h0000, 0, 0, 0, 16'h0000, 0));
        tbl.push_back(v("ld_done", 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hBEEF, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 5, 0, 16'hBEEF, 0));
        tbl.push_back(v("ld_hold", 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 5, 0, 16'hBEEF, 0));
        // single store; memory rdata must be ignored
        tbl.push_back(v("st_push", 0, 1, 16'h0010, 16'h55AA, 1, 3, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 5, 0, 16'hBEEF, 0));
        tbl.push_back(v("st_iss",  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0010, 16'h55AA, 0, 5, 0, 16'hBEEF, 0));
        tbl.push_back(v("st_done", 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hFFFF, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 3, 1, 16'h0000, 0));
        tbl.push_back(v("st_hold", 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 3, 1, 16'h0000, 0));
        // fill to full, 5th request ignored, then four back-to-back completions
        tbl.push_back(v("b2b_p1",  0, 1, 16'h0101, 16'h0000, 0, 1, 1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 3, 1, 16'h0000, 0));
        tbl.push_back(v("b2b_p2",  0, 1, 16'h0102, 16'h2222, 1, 2, 0, 0, 16'h0000, 0, 2, 1, 0, 16'h0101, 16'h0000, 0, 3, 1, 16'h0000, 0));
        tbl.push_back(v("b2b_p3",  0, 1, 16'h0103, 16'h0000, 0, 3, 1, 0, 16'h0000, 0, 3, 1, 0, 16'h0101, 16'h0000, 0, 3, 1, 16'h0000, 0));
        tbl.push_back(v("b2b_p4",  0, 1, 16'h0104, 16'h4444, 1, 4, 0, 0, 16'h0000, 1, 4, 1, 0, 16'h0101, 16'h0000, 0, 3, 1, 16'h0000, 0));
        tbl.push_back(v("b2b_p5x", 0, 1, 16'h0105, 16'h5555, 0, 5, 1, 0, 16'h0000, 1, 4, 1, 0, 16'h0101, 16'h0000, 0, 3, 1, 16'h0000, 0));
        tbl.push_back(v("b2b_c1",  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hA001, 0, 3, 0, 1, 16'h0102, 16'h2222, 1, 1, 0, 16'hA001, 0));
        tbl.push_back(v("b2b_c2",  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hA002, 0, 2, 1, 0, 16'h0103, 16'h0000, 1, 2, 1, 16'h0000, 0));
        tbl.push_back(v("b2b_c3",  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hA003, 0, 1, 0, 1, 16'h0104, 16'h4444, 1, 3, 0, 16'hA003, 0));
        tbl.push_back(v("b2b_c4",  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hA004, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 4, 1, 16'h0000, 0));
        tbl.push_back(v("b2b_end", 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 4, 1, 16'h0000, 0));
        // full boundary: completion and bs on the same edge, bs rejected then retried
        tbl.push_back(v("fb_p1",   0, 1, 16'h0201, 16'h0000, 0, 6, 1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 4, 1, 16'h0000, 0));
        tbl.push_back(v("fb_p2",   0, 1, 16'h0202, 16'h0000, 0, 7, 1, 0, 16'h0000, 0, 2, 1, 0, 16'h0201, 16'h0000, 0, 4, 1, 16'h0000, 0));
        tbl.push_back(v("fb_p3",   0, 1, 16'h0203, 16'h0000, 0, 8, 1, 0, 16'h0000, 0, 3, 1, 0, 16'h0201, 16'h0000, 0, 4, 1, 16'h0000, 0));
        tbl.push_back(v("fb_p4",   0, 1, 16'h0204, 16'h0000, 0, 9, 1, 0, 16'h0000, 1, 4, 1, 0, 16'h0201, 16'h0000, 0, 4, 1, 16'h0000, 0));
        tbl.push_back(v("fb_rej",  0, 1, 16'h0205, 16'h0000, 1, 10, 1, 1, 16'hB001, 0, 3, 1, 0, 16'h0202, 16'h0000, 1, 6, 0, 16'hB001, 0));
        tbl.push_back(v("fb_retry",0, 1, 16'h0205, 16'h0000, 1, 10, 1, 0, 16'h0000, 1, 4, 1, 0, 16'h0202, 16'h0000, 0, 6, 0, 16'hB001, 0));
        tbl.push_back(v("fb_c2",   0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hC002, 0, 3, 1, 0, 16'h0203, 16'h0000, 1, 7, 0, 16'hC002, 0));
        tbl.push_back(v("fb_c3",   0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hC003, 0, 2, 1, 0, 16'h0204, 16'h0000, 1, 8, 0, 16'hC003, 0));
        tbl.push_back(v("fb_c4",   0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hC004, 0, 1, 1, 0, 16'h0205, 16'h0000, 1, 9, 0, 16'hC004, 0));
        tbl.push_back(v("fb_c5",   0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hC005, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 10, 1, 16'hC005, 0));
        tbl.push_back(v("fb_end",  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 10, 1, 16'hC005, 0));

        rst = 1'b1;
        foreach (tbl[i]) apply(tbl[i]);

        // timeout: two loads, memory never answers the first
        apply(v("to_p1",   0, 1, 16'h0301, 16'h0000, 0, 11, 1, 0, 16'hFFFF, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 10, 1, 16'hC005, 0));
        apply(v("to_p2",   0, 1, 16'h0302, 16'h0000, 1, 12, 1, 0, 16'hFFFF, 0, 2, 1, 0, 16'h0301, 16'h0000, 0, 10, 1, 16'hC005, 0));
        // busy cycles 1..7 end without completion
        for (int k = 0; k < 7; k++)
            apply(v("to_wait", 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 0, 2, 1, 0, 16'h0301, 16'h0000, 0, 10, 1, 16'hC005, 0));
        // end of 8th busy cycle: abort with error, next entry issued
        apply(v("to_abort",0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 0, 1, 1, 0, 16'h0302, 16'h0000, 1, 11, 0, 16'h0000, 1));
        for (int k = 0; k < 7; k++)
            apply(v("to_wait2",0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 0, 1, 1, 0, 16'h0302, 16'h0000, 0, 11, 0, 16'h0000, 1));
        // ready on the 8th cycle beats the timeout
        apply(v("to_rdy8", 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hD00D, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 12, 1, 16'hD00D, 0));
        apply(v("to_end",  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 12, 1, 16'hD00D, 0));

        // reset while busy with three queued
        apply(v("mr_p1",   0, 1, 16'h0401, 16'h1111, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 12, 1, 16'hD00D, 0));
        apply(v("mr_p2",   0, 1, 16'h0402, 16'h2222, 0, 2, 0, 0, 16'h0000, 0, 2, 0, 1, 16'h0401, 16'h1111, 0, 12, 1, 16'hD00D, 0));
        apply(v("mr_p3",   0, 1, 16'h0403, 16'h3333, 0, 3, 1, 0, 16'h0000, 0, 3, 0, 1, 16'h0401, 16'h1111, 0, 12, 1, 16'hD00D, 0));
        apply(v("mr_rst",  1, 1, 16'h0404, 16'h4444, 1, 4, 1, 1, 16'hEEEE, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0));
        apply(v("mr_post", 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hEEEE, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0));
        apply(v("mr_idle", 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
